// File: rtl/decoder_secded.sv
// decoder_secded: two-stage streaming SECDED decoder for 8/16/32-bit right-aligned Hamming codewords.
// Define DECODER_ERR_CNT_EN to build the corrected/uncorrectable word counters (corr_cnt, uncorr_cnt).
module decoder_secded #(
    parameter int AMBA_WORD = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [1:0]           CODEWORD_WIDTH,
    input  logic [AMBA_WORD-1:0] DATA_IN,
    input  logic                 cnt_clr,
    output logic                 out_valid,
    output logic [AMBA_WORD-1:0] DATA_OUT,
    output logic [1:0]           NUM_OF_ERRORS,
    output logic [15:0]          corr_cnt,
    output logic [15:0]          uncorr_cnt
);
    localparam int         SD     = 4;
    localparam int         MD     = 11;
    localparam int         LD     = 26;
    localparam logic [1:0] MODE_S = 2'b00;
    localparam logic [1:0] MODE_M = 2'b01;

    // Small data-bit H columns as {C5,C6,C7,C8}; index 0 is the data LSB (codeword bit 4).
    function automatic logic [3:0] hcol_s(input int k);
        logic [3:0] c;
        case (k)
            0:       c = 4'b1011;
            1:       c = 4'b1101;
            2:       c = 4'b1110;
            default: c = 4'b0111;
        endcase
        return c;
    endfunction

    // Medium/Large data-bit H columns: the odd-weight (3 or 5) values in ascending order.
    // The first 11 entries all fit in 5 bits and form the Medium matrix.
    function automatic logic [5:0] hcol(input int k);
        logic [5:0] c;
        case (k)
            0:  c = 6'd7;   1:  c = 6'd11;  2:  c = 6'd13;  3:  c = 6'd14;
            4:  c = 6'd19;  5:  c = 6'd21;  6:  c = 6'd22;  7:  c = 6'd25;
            8:  c = 6'd26;  9:  c = 6'd28;  10: c = 6'd31;  11: c = 6'd35;
            12: c = 6'd37;  13: c = 6'd38;  14: c = 6'd41;  15: c = 6'd42;
            16: c = 6'd44;  17: c = 6'd47;  18: c = 6'd49;  19: c = 6'd50;
            20: c = 6'd52;  21: c = 6'd55;  22: c = 6'd56;  23: c = 6'd59;
            24: c = 6'd61;  25: c = 6'd62;
            default: c = 6'd0;
        endcase
        return c;
    endfunction

    logic [2:1]           vld_pipe;
    logic [AMBA_WORD-1:0] cw_q;
    logic [1:0]           mode_q;
    logic [5:0]           syn_s, syn_m, syn_l, syn_d, syn_q;

    // Syndrome starts from the received checks and folds in the recomputed ones.
    always_comb begin
        syn_s = {2'b00, DATA_IN[3:0]};
        syn_m = {1'b0, DATA_IN[4:0]};
        syn_l = DATA_IN[5:0];
        for (int k = 0; k < SD; k++)
            if (DATA_IN[4+k]) syn_s = syn_s ^ {2'b00, hcol_s(k)};
        for (int k = 0; k < MD; k++)
            if (DATA_IN[5+k]) syn_m = syn_m ^ hcol(k);
        for (int k = 0; k < LD; k++)
            if (DATA_IN[6+k]) syn_l = syn_l ^ hcol(k);
        case (CODEWORD_WIDTH)
            MODE_S:  syn_d = syn_s;
            MODE_M:  syn_d = syn_m;
            default: syn_d = syn_l;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            cw_q     <= '0;
            mode_q   <= '0;
            syn_q    <= '0;
        end else begin
            vld_pipe <= {vld_pipe[1], in_valid};
            if (in_valid) begin
                cw_q   <= DATA_IN;
                mode_q <= CODEWORD_WIDTH;
                syn_q  <= syn_d;
            end
        end
    end

    logic [AMBA_WORD-1:0] data_raw, flip;
    logic [1:0]           nerr_d;
    logic                 chk_col;

    always_comb begin
        data_raw = '0;
        flip     = '0;
        case (mode_q)
            MODE_S: begin
                data_raw[SD-1:0] = cw_q[7:4];
                for (int k = 0; k < SD; k++)
                    if (syn_q == {2'b00, hcol_s(k)}) flip[k] = 1'b1;
            end
            MODE_M: begin
                data_raw[MD-1:0] = cw_q[15:5];
                for (int k = 0; k < MD; k++)
                    if (syn_q == hcol(k)) flip[k] = 1'b1;
            end
            default: begin
                data_raw[LD-1:0] = cw_q[31:6];
                for (int k = 0; k < LD; k++)
                    if (syn_q == hcol(k)) flip[k] = 1'b1;
            end
        endcase
        // Weight-1 syndrome: the error hit a check bit, so the data is already good.
        chk_col = ((syn_q & (syn_q - 6'd1)) == 6'd0);
        if (syn_q == 6'd0)
            nerr_d = 2'd0;
        else if (chk_col || (|flip))
            nerr_d = 2'd1;
        else
            nerr_d = 2'd2;
    end

    assign out_valid = vld_pipe[2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            DATA_OUT      <= '0;
            NUM_OF_ERRORS <= '0;
        end else if (vld_pipe[1]) begin
            DATA_OUT      <= data_raw ^ flip;
            NUM_OF_ERRORS <= nerr_d;
        end
    end

`ifdef DECODER_ERR_CNT_EN
    logic inc_corr, inc_uncorr;
    assign inc_corr   = vld_pipe[1] && (nerr_d == 2'd1);
    assign inc_uncorr = vld_pipe[1] && (nerr_d == 2'd2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (cnt_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else begin
            if (inc_corr && corr_cnt != 16'hFFFF)
                corr_cnt <= corr_cnt + 16'd1;
            if (inc_uncorr && uncorr_cnt != 16'hFFFF)
                uncorr_cnt <= uncorr_cnt + 16'd1;
        end
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign corr_cnt       = '0;
    assign uncorr_cnt     = '0;
`endif

endmodule
